data_bus_arbiter: RTL and testbench
===================================

// Module: data_bus_arbiter
// PURPOSE
//  Two-master arbiter for the MEM-stage data bus feeding master_memory_map (RAM/UART).
//  Master 0 = core MEM stage; master 1 = UART program loader.
//  Serialises accesses and holds each latched request for a programmable slave latency.
//  Provides a stall request to the pipeline hazard logic while the core waits.
// PARAMETERS
//  DATA_WIDTH  32  data bus width
//  ADDR_WIDTH  32  address bus width
//  ACCESS_LAT  1   slave cycles per access (>=1); CNT_W = $clog2(ACCESS_LAT+1) localparam
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  m0_req       in   1   core request; held with m0_we/addr/wd until m0_done
//  m0_we        in   1   1=write, 0=read
//  m0_addr      in   AW  byte address
//  m0_wd        in   DW  write data
//  m0_gnt       out  1   core owns bus (ACCESS+RESP)
//  m0_done      out  1   1-cycle completion pulse; m0_rd valid this cycle
//  m0_rd        out  DW  read data (registered)
//  m1_req/m1_we/m1_addr/m1_wd/m1_gnt/m1_done/m1_rd   same for loader
//  m1_lock      in   1   loader burst lock (ARB_LOCK_EN only)
//  s_we         out  1   slave write strobe (to memory map .we)
//  s_re         out  1   slave read enable (to memory map .re)
//  s_addr       out  AW  latched address
//  s_wd         out  DW  latched write data
//  s_rd         in   DW  slave read data
//  core_stall   out  1   = m0_req & ~m0_done (combinational)
// BEHAVIOUR
//  Reset: state=IDLE, all gnt/done/s_we/s_re=0, m*_rd=0, s_addr/s_wd=0, last_served=LOADER.
//  FSM: IDLE -> ACCESS -> RESP -> IDLE.
//   IDLE: if any req, pick winner, latch we/addr/wd/owner, cnt=ACCESS_LAT-1 -> ACCESS.
//   ACCESS: gnt[owner]=1; s_re=~we held all ACCESS cycles; s_we=we ONLY on first ACCESS
//           cycle (no UART double-write); cnt==0: capture s_rd into owner rd reg -> RESP;
//           else cnt-1.
//   RESP: gnt[owner]=1, done[owner]=1 one cycle, last_served=owner -> IDLE.
//  Latency: req sampled in IDLE cycle t -> done at t+ACCESS_LAT+1; one access per ACCESS_LAT+2.
//  Arbitration: round-robin; both req in IDLE -> master != last_served wins; single req wins.
//  Request dropped after latch: access still completes, done still pulses.
//  Req still high in RESP cycle is not re-served until the next IDLE (master must drop it).
//  Non-owner rd reg holds its value; rd regs change only on capture.
//  Reset mid-operation: outputs clear immediately (async); no done issued; next access from IDLE.
//  Non-owner request during ACCESS/RESP: ignored, served at next IDLE.
// CONFIGURATION
//  ARB_LOCK_EN defined: in IDLE, if m1_lock & m1_req, loader wins regardless of last_served
//   (bursted image load); core stalls until lock drops.
//  ARB_LOCK_EN undefined: m1_lock ignored; pure round-robin.
// STRUCTURE
//  Package data_bus_arb_pkg: state typedef ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_RESP=2'd2;
//   owner constants OWN_CORE=1'b0, OWN_LOADER=1'b1.
//  Sub-module arb_rr_picker: 2-way round-robin select + last_served register
//   (inputs req[1:0], lock, update, owner; output winner).
// TESTING
//  1 Core write, LAT=1: m0_req,we=1,addr=0x10010004,wd=0xDEADBEEF -> s_we high exactly
//    1 cycle, s_addr/s_wd match, m0_done at t+2, m1_* quiet.
//  2 Loader read, LAT=2, s_rd=0x00000055 -> s_re high 2 cycles, s_we=0, m1_rd=0x55 with
//    m1_done at t+3.
//  3 Both req held continuously from reset -> grants core, loader, core, loader; every
//    done at a 3-cycle spacing (LAT=1).
//  4 rst pulsed during ACCESS of a write -> s_we/s_re/gnt 0 same cycle, no done; next
//    req completes normally.
//  5 m0_req dropped in first ACCESS cycle -> m0_done still pulses; core_stall follows m0_req.
//  6 ARB_LOCK_EN, m1_lock=1, both requesting -> loader served 3 consecutive times; lock=0
//    -> core next. Without macro -> strict alternation.

Source files
------------

// File: rtl/data_bus_arb_pkg.sv
// Shared types for the two-master data bus arbiter: FSM state encoding and owner ids.
package data_bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  localparam logic OWN_CORE   = 1'b0;
  localparam logic OWN_LOADER = 1'b1;

endpackage

// File: rtl/data_bus_arbiter_if.sv
// Bus bundle between the core/loader masters, the arbiter and the memory-map slave port.
interface data_bus_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  m0_req;
  logic                  m0_we;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [DATA_WIDTH-1:0] m0_wd;
  logic                  m0_gnt;
  logic                  m0_done;
  logic [DATA_WIDTH-1:0] m0_rd;

  logic                  m1_req;
  logic                  m1_we;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0] m1_wd;
  logic                  m1_gnt;
  logic                  m1_done;
  logic [DATA_WIDTH-1:0] m1_rd;
  logic                  m1_lock;

  logic                  s_we;
  logic                  s_re;
  logic [ADDR_WIDTH-1:0] s_addr;
  logic [DATA_WIDTH-1:0] s_wd;
  logic [DATA_WIDTH-1:0] s_rd;

  logic                  core_stall;

  // Arbiter side.
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wd,
    input  m1_req, m1_we, m1_addr, m1_wd, m1_lock,
    input  s_rd,
    output m0_gnt, m0_done, m0_rd,
    output m1_gnt, m1_done, m1_rd,
    output s_we, s_re, s_addr, s_wd,
    output core_stall
  );

  // Masters plus memory-map side, as seen by whoever drives the arbiter.
  modport master (
    output m0_req, m0_we, m0_addr, m0_wd,
    output m1_req, m1_we, m1_addr, m1_wd, m1_lock,
    output s_rd,
    input  m0_gnt, m0_done, m0_rd,
    input  m1_gnt, m1_done, m1_rd,
    input  s_we, s_re, s_addr, s_wd,
    input  core_stall
  );

endinterface

// File: rtl/arb_rr_picker.sv
// Two-way round-robin winner select with the last-served register.
// ARB_LOCK_EN: a locked loader request wins regardless of history.
module arb_rr_picker
  import data_bus_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_lock,
  input  logic       i_update,
  input  logic       i_owner,
  output logic       o_winner
);

  logic r_last_served;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_served <= OWN_LOADER;
    end else if (i_update) begin
      r_last_served <= i_owner;
    end
  end

  always_comb begin
    o_winner = OWN_CORE;
    if (i_req == 2'b11) begin
      o_winner = ~r_last_served;
    end else if (i_req[1]) begin
      o_winner = OWN_LOADER;
    end
`ifdef ARB_LOCK_EN
    if (i_lock && i_req[1]) begin
      o_winner = OWN_LOADER;
    end
`endif
  end

`ifndef ARB_LOCK_EN
  logic w_lock_unused;
  assign w_lock_unused = i_lock;
`endif

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master (core / UART loader) arbiter for the MEM-stage data bus, IDLE->ACCESS->RESP.
// ARB_LOCK_EN enables the loader burst lock; undefined gives pure round-robin.
module data_bus_arbiter
  import data_bus_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ACCESS_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  data_bus_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(ACCESS_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ACCESS_LAT - 1);

  arb_state_e            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_owner;
  logic [1:0]            r_gnt;
  logic [1:0]            r_done;
  logic                  r_s_we;
  logic                  r_s_re;
  logic [ADDR_WIDTH-1:0] r_s_addr;
  logic [DATA_WIDTH-1:0] r_s_wd;
  logic [DATA_WIDTH-1:0] r_rd0;
  logic [DATA_WIDTH-1:0] r_rd1;

  logic                  w_winner;
  logic                  w_update;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wd;

  assign w_update   = (r_state == ST_RESP);
  assign w_sel_we   = w_winner ? bus.m1_we   : bus.m0_we;
  assign w_sel_addr = w_winner ? bus.m1_addr : bus.m0_addr;
  assign w_sel_wd   = w_winner ? bus.m1_wd   : bus.m0_wd;

  arb_rr_picker u_picker (
    .clk      (clk),
    .rst      (rst),
    .i_req    ({bus.m1_req, bus.m0_req}),
    .i_lock   (bus.m1_lock),
    .i_update (w_update),
    .i_owner  (r_owner),
    .o_winner (w_winner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_owner  <= OWN_CORE;
      r_gnt    <= '0;
      r_done   <= '0;
      r_s_we   <= 1'b0;
      r_s_re   <= 1'b0;
      r_s_addr <= '0;
      r_s_wd   <= '0;
      r_rd0    <= '0;
      r_rd1    <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.m0_req || bus.m1_req) begin
            r_owner  <= w_winner;
            r_gnt    <= w_winner ? 2'b10 : 2'b01;
            r_s_we   <= w_sel_we;
            r_s_re   <= ~w_sel_we;
            r_s_addr <= w_sel_addr;
            r_s_wd   <= w_sel_wd;
            r_cnt    <= CNT_INIT;
            r_state  <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // Write strobe lasts one cycle so a slow slave never sees a repeated write.
          r_s_we <= 1'b0;
          if (r_cnt == '0) begin
            r_s_re          <= 1'b0;
            r_done[r_owner] <= 1'b1;
            if (r_owner == OWN_LOADER) begin
              r_rd1 <= bus.s_rd;
            end else begin
              r_rd0 <= bus.s_rd;
            end
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          r_gnt   <= '0;
          r_done  <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.m0_gnt     = r_gnt[0];
  assign bus.m1_gnt     = r_gnt[1];
  assign bus.m0_done    = r_done[0];
  assign bus.m1_done    = r_done[1];
  assign bus.m0_rd      = r_rd0;
  assign bus.m1_rd      = r_rd1;
  assign bus.s_we       = r_s_we;
  assign bus.s_re       = r_s_re;
  assign bus.s_addr     = r_s_addr;
  assign bus.s_wd       = r_s_wd;
  assign bus.core_stall = bus.m0_req & ~r_done[0];

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: transaction-level model checked every cycle, plus directed cases.
module tb_data_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_bus_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus_a ();
  data_bus_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus_b ();

  data_bus_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ACCESS_LAT(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  data_bus_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ACCESS_LAT(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        req0, we0, req1, we1, lock;
    logic        gnt0, gnt1, done0, done1, s_we, s_re, stall;
    logic [31:0] addr0, wd0, addr1, wd1, s_rd, rd0, rd1, s_addr, s_wd;
  } obs_t;

  function automatic obs_t observe(input int id);
    obs_t o;
    if (id == 0) begin
      o.req0 = bus_a.m0_req; o.we0 = bus_a.m0_we; o.addr0 = bus_a.m0_addr; o.wd0 = bus_a.m0_wd;
      o.req1 = bus_a.m1_req; o.we1 = bus_a.m1_we; o.addr1 = bus_a.m1_addr; o.wd1 = bus_a.m1_wd;
      o.lock = bus_a.m1_lock; o.s_rd = bus_a.s_rd;
      o.gnt0 = bus_a.m0_gnt; o.gnt1 = bus_a.m1_gnt; o.done0 = bus_a.m0_done;
      o.done1 = bus_a.m1_done; o.rd0 = bus_a.m0_rd; o.rd1 = bus_a.m1_rd;
      o.s_we = bus_a.s_we; o.s_re = bus_a.s_re; o.s_addr = bus_a.s_addr; o.s_wd = bus_a.s_wd;
      o.stall = bus_a.core_stall;
    end else begin
      o.req0 = bus_b.m0_req; o.we0 = bus_b.m0_we; o.addr0 = bus_b.m0_addr; o.wd0 = bus_b.m0_wd;
      o.req1 = bus_b.m1_req; o.we1 = bus_b.m1_we; o.addr1 = bus_b.m1_addr; o.wd1 = bus_b.m1_wd;
      o.lock = bus_b.m1_lock; o.s_rd = bus_b.s_rd;
      o.gnt0 = bus_b.m0_gnt; o.gnt1 = bus_b.m1_gnt; o.done0 = bus_b.m0_done;
      o.done1 = bus_b.m1_done; o.rd0 = bus_b.m0_rd; o.rd1 = bus_b.m1_rd;
      o.s_we = bus_b.s_we; o.s_re = bus_b.s_re; o.s_addr = bus_b.s_addr; o.s_wd = bus_b.s_wd;
      o.stall = bus_b.core_stall;
    end
    return o;
  endfunction

  // Model: one access at a time, started in cycle st; grant covers st+1..st+L+1,
  // done at st+L+1, read data is whatever s_rd showed in cycle st+L.
  int          m_lat   [2] = '{1, 2};
  bit          m_busy  [2];
  int          m_st    [2];
  bit          m_own   [2];
  bit          m_we    [2];
  bit          m_last  [2];
  int          m_free  [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wd    [2];
  logic [31:0] m_rd0   [2];
  logic [31:0] m_rd1   [2];

  task automatic model_reset(input int id);
    m_busy[id] = 1'b0; m_last[id] = 1'b1; m_free[id] = cyc + 1;
    m_addr[id] = '0; m_wd[id] = '0; m_rd0[id] = '0; m_rd1[id] = '0;
  endtask

  task automatic model_step(input int id);
    obs_t  o;
    int    k, st, l;
    bit    in_acc, in_resp, w;
    string p;
    o  = observe(id);
    k  = cyc;
    st = m_st[id];
    l  = m_lat[id];
    p  = (id == 0) ? "a" : "b";
    if (rst) begin
      model_reset(id);
    end
    in_acc  = m_busy[id] && k >= st + 1 && k <= st + l;
    in_resp = m_busy[id] && k == st + l + 1;
    chk({p, ".m0_gnt"},  o.gnt0,  (in_acc || in_resp) && !m_own[id]);
    chk({p, ".m1_gnt"},  o.gnt1,  (in_acc || in_resp) && m_own[id]);
    chk({p, ".m0_done"}, o.done0, in_resp && !m_own[id]);
    chk({p, ".m1_done"}, o.done1, in_resp && m_own[id]);
    chk({p, ".s_we"},    o.s_we,  m_busy[id] && m_we[id] && k == st + 1);
    chk({p, ".s_re"},    o.s_re,  in_acc && !m_we[id]);
    chk({p, ".s_addr"},  o.s_addr, m_addr[id]);
    chk({p, ".s_wd"},    o.s_wd,   m_wd[id]);
    chk({p, ".m0_rd"},   o.rd0,    m_rd0[id]);
    chk({p, ".m1_rd"},   o.rd1,    m_rd1[id]);
    chk({p, ".core_stall"}, o.stall, o.req0 && !(in_resp && !m_own[id]));
    if (rst) return;
    if (m_busy[id] && k == st + l) begin
      if (m_own[id]) m_rd1[id] = o.s_rd;
      else           m_rd0[id] = o.s_rd;
    end
    if (in_resp) begin
      m_last[id] = m_own[id];
      m_busy[id] = 1'b0;
    end
    if (!m_busy[id] && k >= m_free[id] && (o.req0 || o.req1)) begin
      if (o.req0 && o.req1) w = !m_last[id];
      else                  w = o.req1;
`ifdef ARB_LOCK_EN
      if (o.lock && o.req1) w = 1'b1;
`endif
      m_busy[id] = 1'b1;
      m_st[id]   = k;
      m_own[id]  = w;
      m_we[id]   = w ? o.we1 : o.we0;
      m_addr[id] = w ? o.addr1 : o.addr0;
      m_wd[id]   = w ? o.wd1 : o.wd0;
      m_free[id] = k + l + 2;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int id = 0; id < 2; id++) model_step(id);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int q_own[$];
  int q_cyc[$];

  // Records done pulses on bus_a; drops the loader lock once drop_at dones were seen.
  task automatic collect(input int want, input int drop_at);
    q_own.delete();
    q_cyc.delete();
    for (int i = 0; i < 40 && q_own.size() < want; i++) begin
      @(negedge clk);
      if (bus_a.m0_done) begin q_own.push_back(0); q_cyc.push_back(cyc); end
      if (bus_a.m1_done) begin q_own.push_back(1); q_cyc.push_back(cyc); end
      step();
      if (q_own.size() >= drop_at) bus_a.m1_lock = 1'b0;
    end
    chk("collect_count", q_own.size(), want);
  endtask

  int j;
  int got;
  int exp_own[4];

  initial begin
    bus_a.m0_req = 0; bus_a.m0_we = 0; bus_a.m0_addr = 0; bus_a.m0_wd = 0;
    bus_a.m1_req = 0; bus_a.m1_we = 0; bus_a.m1_addr = 0; bus_a.m1_wd = 0;
    bus_a.m1_lock = 0; bus_a.s_rd = 0;
    bus_b.m0_req = 0; bus_b.m0_we = 0; bus_b.m0_addr = 0; bus_b.m0_wd = 0;
    bus_b.m1_req = 0; bus_b.m1_we = 0; bus_b.m1_addr = 0; bus_b.m1_wd = 0;
    bus_b.m1_lock = 0; bus_b.s_rd = 0;
    @(negedge clk);
    chk("rst_m0_gnt", bus_a.m0_gnt, 0);
    chk("rst_s_addr", bus_a.s_addr, 0);
    chk("rst_m1_rd", bus_b.m1_rd, 0);
    step(); step();
    rst = 1'b0;

    // Core write, latency 1.
    step();
    bus_a.m0_req = 1; bus_a.m0_we = 1; bus_a.m0_addr = 32'h1001_0004; bus_a.m0_wd = 32'hDEAD_BEEF;
    @(negedge clk); chk("t1_stall", bus_a.core_stall, 1);
    step(); @(negedge clk);
    chk("t1_s_we", bus_a.s_we, 1);
    chk("t1_s_addr", bus_a.s_addr, 32'h1001_0004);
    chk("t1_s_wd", bus_a.s_wd, 32'hDEAD_BEEF);
    chk("t1_m1_gnt", bus_a.m1_gnt, 0);
    step(); @(negedge clk);
    chk("t1_done", bus_a.m0_done, 1);
    chk("t1_s_we_off", bus_a.s_we, 0);
    step();
    bus_a.m0_req = 0;

    // Loader read, latency 2.
    bus_b.m1_req = 1; bus_b.m1_we = 0; bus_b.m1_addr = 32'h0000_0200; bus_b.s_rd = 32'h55;
    @(negedge clk);
    step(); @(negedge clk);
    chk("t2_s_re_1", bus_b.s_re, 1);
    chk("t2_s_we", bus_b.s_we, 0);
    step(); @(negedge clk);
    chk("t2_s_re_2", bus_b.s_re, 1);
    chk("t2_early_done", bus_b.m1_done, 0);
    step(); @(negedge clk);
    chk("t2_done", bus_b.m1_done, 1);
    chk("t2_m1_rd", bus_b.m1_rd, 32'h55);
    step();
    bus_b.m1_req = 0;

    // Both requesting from reset: strict alternation, 3-cycle spacing.
    rst = 1;
    bus_a.m0_req = 1; bus_a.m0_we = 1; bus_a.m0_addr = 32'h100; bus_a.m0_wd = 32'hA;
    bus_a.m1_req = 1; bus_a.m1_we = 0; bus_a.m1_addr = 32'h104; bus_a.s_rd = 32'h77;
    step();
    rst = 0;
    j = cyc;
    collect(4, 99);
    bus_a.m0_req = 0; bus_a.m1_req = 0;
    chk("t3_first_done", q_cyc[0] - j, 2);
    for (int i = 0; i < 4; i++) chk($sformatf("t3_owner%0d", i), q_own[i], i % 2);
    for (int i = 1; i < 4; i++) chk($sformatf("t3_gap%0d", i), q_cyc[i] - q_cyc[i-1], 3);
    step(); step();

    // Reset during the ACCESS cycle of a write.
    bus_a.m0_req = 1; bus_a.m0_we = 1; bus_a.m0_addr = 32'h1001_0008; bus_a.m0_wd = 32'hCAFE_F00D;
    @(negedge clk);
    step(); @(negedge clk);
    chk("t4_s_we_pre", bus_a.s_we, 1);
    #2 rst = 1;
    #1;
    chk("t4_s_we", bus_a.s_we, 0);
    chk("t4_s_re", bus_a.s_re, 0);
    chk("t4_gnt", bus_a.m0_gnt, 0);
    step(); step();
    rst = 0;
    j = cyc;
    got = -1;
    for (int i = 0; i < 10 && got < 0; i++) begin
      @(negedge clk);
      if (bus_a.m0_done) got = cyc - j;
      step();
    end
    chk("t4_redone", got, 2);
    bus_a.m0_req = 0;
    step();

    // Request dropped in the first ACCESS cycle.
    bus_a.m0_req = 1; bus_a.m0_we = 0; bus_a.m0_addr = 32'h1001_0004; bus_a.s_rd = 32'h1234_5678;
    @(negedge clk); chk("t5_stall_on", bus_a.core_stall, 1);
    step();
    bus_a.m0_req = 0;
    @(negedge clk);
    chk("t5_stall_off", bus_a.core_stall, 0);
    chk("t5_gnt", bus_a.m0_gnt, 1);
    step(); @(negedge clk);
    chk("t5_done", bus_a.m0_done, 1);
    chk("t5_rd", bus_a.m0_rd, 32'h1234_5678);
    step();

    // Loader lock with both requesting.
    rst = 1;
    bus_a.m0_req = 1; bus_a.m0_we = 1; bus_a.m0_addr = 32'h300; bus_a.m0_wd = 32'hB;
    bus_a.m1_req = 1; bus_a.m1_we = 0; bus_a.m1_addr = 32'h304; bus_a.m1_lock = 1;
    step();
    rst = 0;
    collect(4, 3);
    bus_a.m0_req = 0; bus_a.m1_req = 0;
`ifdef ARB_LOCK_EN
    exp_own = '{1, 1, 1, 0};
`else
    exp_own = '{0, 1, 0, 1};
`endif
    for (int i = 0; i < 4; i++) chk($sformatf("t6_owner%0d", i), q_own[i], exp_own[i]);
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
